// File: rtl/dvi_timing_ctrl.sv
// DVI video timing generator with PLL-lock start-up sequencing and frame-aligned stop.
// Optional define DVI_FRAME_COUNTER_EN adds a 16-bit frame_count output.
module dvi_timing_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOCK_WAIT = 1024,
  parameter int CW        = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pll_locked,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef DVI_FRAME_COUNTER_EN
  , output logic [15:0] frame_count
`endif
);
  localparam int HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LW_W = $clog2(LOCK_WAIT + 1);

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [LW_W-1:0] LW_MAX = LW_W'(LOCK_WAIT);

  // bit 1 set means timing is live (RUN or DRAIN)
  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state, state_n;
  logic [CW-1:0]   h, v, h_n, v_n;
  logic [LW_W-1:0] lock_cnt, lock_cnt_n;
  logic            h_last, v_last;
  logic            act_n, de_n, hs_on, vs_on, ls_n, fs_n;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  always_comb begin
    state_n    = state;
    h_n        = h;
    v_n        = v;
    lock_cnt_n = lock_cnt;
    case (state)
      S_OFF:
        if (enable) begin
          state_n    = S_WAIT;
          lock_cnt_n = '0;
        end
      S_WAIT:
        if (!enable) begin
          state_n    = S_OFF;
          lock_cnt_n = '0;
        end else if (!pll_locked) begin
          lock_cnt_n = '0;
        end else if (lock_cnt == LW_MAX) begin
          state_n    = S_RUN;
          lock_cnt_n = '0;
          h_n        = '0;
          v_n        = '0;
        end else begin
          lock_cnt_n = lock_cnt + LW_W'(1);
        end
      default:
        if (!pll_locked) begin
          // lost lock: abandon the partial frame
          state_n    = enable ? S_WAIT : S_OFF;
          lock_cnt_n = '0;
          h_n        = '0;
          v_n        = '0;
        end else if (state == S_DRAIN && !enable && h_last && v_last) begin
          state_n = S_OFF;
          h_n     = '0;
          v_n     = '0;
        end else begin
          state_n = enable ? S_RUN : S_DRAIN;
          h_n     = h_last ? '0 : h + CW'(1);
          if (h_last) v_n = v_last ? '0 : v + CW'(1);
        end
    endcase
  end

  // outputs are decoded from next-state counters so they register alongside h/v
  assign act_n = state_n[1];
  assign de_n  = act_n && (h_n < H_ACT) && (v_n < V_ACT);
  assign hs_on = act_n && (h_n >= H_SS) && (h_n < H_SE);
  assign vs_on = act_n && (v_n >= V_SS) && (v_n < V_SE);
  assign ls_n  = act_n && (h_n == '0);
  assign fs_n  = ls_n && (v_n == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_OFF;
      h           <= '0;
      v           <= '0;
      lock_cnt    <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_n;
      h           <= h_n;
      v           <= v_n;
      lock_cnt    <= lock_cnt_n;
      hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      de          <= de_n;
      x           <= de_n ? h_n : '0;
      y           <= de_n ? v_n : '0;
      line_start  <= ls_n;
      frame_start <= fs_n;
      running     <= act_n;
    end
  end

`ifdef DVI_FRAME_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     frame_count <= '0;
    else if (fs_n) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Randomized bench for dvi_timing_ctrl: reduced timing, frame-position reference model.
module tb_dvi_timing_ctrl;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int LW = 20, CW = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, lk = 1'b0;
  logic hsync, vsync, de, line_start, frame_start, running;
  logic [CW-1:0] x, y;
`ifdef DVI_FRAME_COUNTER_EN
  logic [15:0] frame_count;
`endif

  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_WAIT(LW), .CW(CW)
  ) dut (
    .clk(clk), .reset(rst), .pll_locked(lk), .enable(en),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
`ifdef DVI_FRAME_COUNTER_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: mode 0 off, 1 waiting for lock, 2 run, 3 drain; pos = linear pixel index in frame
  int mode = 0, lcnt = 0, pos = 0, mfc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = 0; lcnt = 0; pos = 0; mfc = 0;
    end else begin
      if (mode == 0) begin
        if (en) begin mode = 1; lcnt = 0; end
      end else if (mode == 1) begin
        if (!en) begin mode = 0; lcnt = 0; end
        else if (!lk) lcnt = 0;
        else if (lcnt == LW) begin mode = 2; pos = 0; end
        else lcnt++;
      end else begin
        if (!lk) begin mode = en ? 1 : 0; lcnt = 0; pos = 0; end
        else if (mode == 3 && !en && pos == FT - 1) begin mode = 0; pos = 0; end
        else begin mode = en ? 2 : 3; pos = (pos + 1) % FT; end
      end
      if (mode >= 2 && pos == 0) mfc = (mfc + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    logic run, e_de, e_hs, e_vs;
    int h, v;
    logic [2*CW+5:0] ev, av;
    run  = (mode >= 2);
    h    = pos % HT;
    v    = pos / HT;
    e_de = run && h < HA && v < VA;
    e_hs = !(run && h >= HA + HF && h < HA + HF + HS);
    e_vs = !(run && v >= VA + VF && v < VA + VF + VS);
    ev = {e_hs, e_vs, e_de, e_de ? CW'(h) : CW'(0), e_de ? CW'(v) : CW'(0),
          run && h == 0, run && pos == 0, run};
    av = {hsync, vsync, de, x, y, line_start, frame_start, running};
    chk("model_outputs", 64'(av), 64'(ev));
`ifdef DVI_FRAME_COUNTER_EN
    chk("model_frame_count", 64'(frame_count), 64'(mfc));
`endif
  end

  // counts edges (sampled #1 later) until running==want; returns bound on timeout
  task automatic wait_run(input logic want, input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (running !== want && n < bound);
  endtask

  initial begin
    int n, dc, hc, vc, fc;
    repeat (3) @(negedge clk);
    chk("reset_idle", {hsync, vsync, de, x, y, line_start, frame_start, running},
        {1'b1, 1'b1, 1'b0, CW'(0), CW'(0), 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);

    // start-up: running appears LW+1 edges after the edge that samples enable
    lk = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    wait_run(1'b1, 200, n);
    chk("lock_latency", n, LW + 1);
    chk("first_cycle", {frame_start, line_start, de, x, y}, {1'b1, 1'b1, 1'b1, CW'(0), CW'(0)});
`ifdef DVI_FRAME_COUNTER_EN
    chk("fc_first", frame_count, 1);
`endif

    // one full frame of statistics
    dc = 0; hc = 0; vc = 0; fc = 0;
    for (int i = 0; i < FT; i++) begin
      dc += de; hc += !hsync; vc += !vsync; fc += frame_start;
      @(posedge clk); #1;
    end
    chk("de_count", dc, HA * VA);
    chk("hsync_low_count", hc, HS * VT);
    chk("vsync_low_count", vc, VS * HT);
    chk("frame_start_count", fc, 1);
    chk("frame_period", frame_start, 1);
`ifdef DVI_FRAME_COUNTER_EN
    chk("fc_second", frame_count, 2);
`endif

    // drop enable at line 3: drain to end of frame, then idle
    repeat (3 * HT) @(posedge clk);
    #1;
    chk("drain_point", {x, y}, {CW'(0), CW'(3)});
    en = 1'b0;
    wait_run(1'b0, 2 * FT, n);
    chk("drain_length", n, FT - 3 * HT);
    chk("drain_idle", {hsync, vsync, de}, 3'b110);
    fc = 0;
    repeat (50) begin @(posedge clk); #1; fc += frame_start; end
    chk("no_fs_after_drain", fc, 0);

    // lock glitch at count 15 restarts the lock wait
    en = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1; lk = 1'b0;
    @(posedge clk); #1; lk = 1'b1;
    wait_run(1'b1, 200, n);
    chk("relock_latency", n, LW + 1);

    // lose lock mid-frame at x=7,y=3 with enable held
    repeat (3 * HT + 7) @(posedge clk);
    #1;
    chk("lock_drop_point", {x, y}, {CW'(7), CW'(3)});
    lk = 1'b0;
    @(posedge clk); #1;
    chk("lock_drop_idle", {running, de, hsync, vsync}, 4'b0011);
    lk = 1'b1;
    wait_run(1'b1, 200, n);
    chk("restart_latency", n, LW + 1);
    chk("restart_origin", {frame_start, de, x, y}, {1'b1, 1'b1, CW'(0), CW'(0)});

    // randomized enable/lock activity against the model
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ($urandom_range(149) == 0) en = ~en;
      if (!lk) lk = 1'b1;
      else if ($urandom_range(399) == 0) lk = 1'b0;
    end

    // asynchronous reset mid-frame
    @(negedge clk);
    en = 1'b1; lk = 1'b1;
    wait_run(1'b1, 400, n);
    repeat (37) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("async_reset_idle", {running, de, hsync, vsync, frame_start, line_start}, 6'b001100);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
